// File: rtl/bf_pkg.sv
// Shared opcode encoding, controller states and defaults for the Brainfuck
// branch controller.
package bf_pkg;

  localparam int PC_W_DEFAULT = 16;

  localparam logic [2:0] OP_INC   = 3'b000;
  localparam logic [2:0] OP_DEC   = 3'b001;
  localparam logic [2:0] OP_RIGHT = 3'b010;
  localparam logic [2:0] OP_LEFT  = 3'b011;
  localparam logic [2:0] OP_LOOP  = 3'b100;
  localparam logic [2:0] OP_END   = 3'b101;
  localparam logic [2:0] OP_OUT   = 3'b110;
  localparam logic [2:0] OP_IN    = 3'b111;

  typedef enum logic [1:0] {
    EXEC     = 2'd0,
    SCAN_FWD = 2'd1,
    SCAN_BWD = 2'd2,
    ERROR    = 2'd3
  } state_t;

endpackage

// File: rtl/bf_depth_counter.sv
// Bracket nesting-depth counter: load-to-one, increment, decrement, with
// "at one" (next decrement reaches zero) and "full" (increment would overflow) flags.
module bf_depth_counter #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load1,
  input  logic               i_inc,
  input  logic               i_dec,
  output logic [DEPTH_W-1:0] o_depth,
  output logic               o_last,
  output logic               o_full
);

  localparam logic [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};

  logic [DEPTH_W-1:0] r_depth;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_depth <= '0;
    end else if (i_load1) begin
      r_depth <= DEPTH_ONE;
    end else if (i_inc) begin
      r_depth <= r_depth + DEPTH_ONE;
    end else if (i_dec) begin
      r_depth <= r_depth - DEPTH_ONE;
    end
  end

  assign o_depth = r_depth;
  assign o_last  = (r_depth == DEPTH_ONE);
  assign o_full  = &r_depth;

endmodule

// File: rtl/bf_branch_ctrl.sv
// Brainfuck branch controller: issues data ops over valid/ready and resolves
// [ / ] by scanning one instruction per cycle, emitting a Mealy PC delta.
module bf_branch_ctrl
  import bf_pkg::*;
#(
  parameter int PC_W    = PC_W_DEFAULT,
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_run,
  input  logic [2:0]         i_op,
  input  logic               i_cell_zero,
  input  logic               i_exec_ready,
  output logic [PC_W-1:0]    o_pc_delta,
  output logic               o_exec_valid,
  output logic [2:0]         o_exec_op,
  output logic               o_scanning,
  output logic               o_error,
  output state_t             o_state,
  output logic [DEPTH_W-1:0] o_depth
);

  // Handshake: an op transfers in a cycle where o_exec_valid and i_exec_ready
  // are both high; while valid and not ready, the PC holds and the op stays.
  localparam logic [PC_W-1:0] PC_INC  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0] PC_DEC  = '1;
  localparam logic [PC_W-1:0] PC_HOLD = '0;

  state_t          r_state;
  state_t          w_next;
  logic            r_error;
  logic [PC_W-1:0] w_pc_delta;
  logic            w_exec_valid;
  logic            w_load1;
  logic            w_inc;
  logic            w_dec;
  logic            w_err_set;
  logic            w_last;
  logic            w_full;

  bf_depth_counter #(.DEPTH_W(DEPTH_W)) u_depth (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load1 (w_load1),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .o_depth (o_depth),
    .o_last  (w_last),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EXEC;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_error <= r_error | w_err_set;
    end
  end

  // Reset is folded in so the outputs are quiet while rst_n is low.
  always_comb begin
    w_next       = r_state;
    w_pc_delta   = PC_HOLD;
    w_exec_valid = 1'b0;
    w_load1      = 1'b0;
    w_inc        = 1'b0;
    w_dec        = 1'b0;
    w_err_set    = 1'b0;
    if (rst_n && i_run) begin
      case (r_state)
        EXEC: begin
          if (i_op == OP_LOOP) begin
            w_pc_delta = PC_INC;
            if (i_cell_zero) begin
              w_next  = SCAN_FWD;
              w_load1 = 1'b1;
            end
          end else if (i_op == OP_END) begin
            if (!i_cell_zero) begin
              w_pc_delta = PC_DEC;
              w_next     = SCAN_BWD;
              w_load1    = 1'b1;
            end else begin
              w_pc_delta = PC_INC;
            end
          end else begin
            w_exec_valid = 1'b1;
            if (i_exec_ready) w_pc_delta = PC_INC;
          end
        end
        SCAN_FWD: begin
          // An overflowing bracket leaves the PC parked on the offending op.
          if (i_op == OP_LOOP && w_full) begin
            w_err_set = 1'b1;
            w_next    = ERROR;
          end else begin
            w_pc_delta = PC_INC;
            if (i_op == OP_LOOP) begin
              w_inc = 1'b1;
            end else if (i_op == OP_END) begin
              w_dec = 1'b1;
              if (w_last) w_next = EXEC;
            end
          end
        end
        SCAN_BWD: begin
          if (i_op == OP_END && w_full) begin
            w_err_set = 1'b1;
            w_next    = ERROR;
          end else if (i_op == OP_END) begin
            w_inc      = 1'b1;
            w_pc_delta = PC_DEC;
          end else if (i_op == OP_LOOP) begin
            w_dec = 1'b1;
            if (w_last) begin
              w_pc_delta = PC_INC;
              w_next     = EXEC;
            end else begin
              w_pc_delta = PC_DEC;
            end
          end else begin
            w_pc_delta = PC_DEC;
          end
        end
        default: begin
          w_next = r_state;
        end
      endcase
    end
  end

  assign o_pc_delta   = w_pc_delta;
  assign o_exec_valid = w_exec_valid;
  assign o_exec_op    = i_op;
  assign o_scanning   = (r_state == SCAN_FWD) || (r_state == SCAN_BWD);
  assign o_error      = r_error;
  assign o_state      = r_state;

endmodule
